// File: rtl/psum_act_pkg.sv
// -----------------------------------------------------------------------------
// psum_act_pkg
// Shared definitions for the partial-sum accumulator / activation block:
//   - activation mode codes (none / ReLU / ReLU6 / hard-swish)
//   - hard-swish constants: 1/6 is approximated as HSWISH_K / 2**HSWISH_SHIFT
//   - clamp and saturate helpers operating on a wide signed intermediate
// No ports (package).
// -----------------------------------------------------------------------------
package psum_act_pkg;

    // Wide enough for y * t * HSWISH_K with the largest accumulator values.
    localparam int WIDE_W = 48;
    typedef logic signed [WIDE_W-1:0] wide_t;

    typedef enum logic [1:0] {
        ACT_NONE   = 2'd0,
        ACT_RELU   = 2'd1,
        ACT_RELU6  = 2'd2,
        ACT_HSWISH = 2'd3
    } act_mode_e;

    localparam int HSWISH_K     = 43;
    localparam int HSWISH_SHIFT = 8;

    function automatic wide_t clamp(input wide_t x, input wide_t lo, input wide_t hi);
        if (x < lo) begin
            return lo;
        end else if (x > hi) begin
            return hi;
        end
        return x;
    endfunction

    // Clamp to the two's-complement range of a data_w-bit signed value.
    function automatic wide_t saturate(input wide_t x, input int data_w);
        wide_t lo;
        wide_t hi;
        lo = -(wide_t'(1) <<< (data_w - 1));
        hi = (wide_t'(1) <<< (data_w - 1)) - wide_t'(1);
        return clamp(x, lo, hi);
    endfunction

endpackage

// File: rtl/act_unit.sv
// -----------------------------------------------------------------------------
// act_unit
// Purely combinational activation stage: takes the biased group sum y and
// produces the saturated activated result.
// Ports:
//   i_y     in  Y_W     signed biased sum (fixed point, FRAC_W fraction bits)
//   i_mode  in  2       activation select (act_mode_e)
//   o_act   out DATA_W  signed activated, saturated result
// -----------------------------------------------------------------------------
module act_unit
    import psum_act_pkg::*;
#(
    parameter int DATA_W = 14,
    parameter int FRAC_W = 8,
    parameter int Y_W    = 21
) (
    input  logic signed [Y_W-1:0]    i_y,
    input  act_mode_e                i_mode,
    output logic signed [DATA_W-1:0] o_act
);

    wide_t w_y;
    wide_t w_six;
    wide_t w_three;
    wide_t w_t;
    wide_t w_prod;
    wide_t w_res;

    // Hard-swish is y * clamp(y+3, 0, 6) / 6; the division is folded into
    // a multiply by HSWISH_K followed by an arithmetic (flooring) shift that
    // also removes the extra FRAC_W bits of the y*t product.
    always_comb begin
        w_y     = wide_t'(i_y);
        w_six   = wide_t'(6) <<< FRAC_W;
        w_three = wide_t'(3) <<< FRAC_W;
        w_t     = clamp(w_y + w_three, wide_t'(0), w_six);
        w_prod  = (w_y * w_t * wide_t'(HSWISH_K)) >>> (FRAC_W + HSWISH_SHIFT);
        w_res   = saturate(w_y, DATA_W);
        case (i_mode)
            ACT_NONE:   w_res = saturate(w_y, DATA_W);
            ACT_RELU:   w_res = saturate((w_y > wide_t'(0)) ? w_y : wide_t'(0), DATA_W);
            ACT_RELU6:  w_res = clamp(w_y, wide_t'(0), w_six);
            ACT_HSWISH: w_res = saturate(w_prod, DATA_W);
            default:    w_res = saturate(w_y, DATA_W);
        endcase
        o_act = DATA_W'(w_res);
    end

endmodule

// File: rtl/psum_accum_act.sv
// -----------------------------------------------------------------------------
// psum_accum_act
// Accumulates per-window partial sums across input-channel groups, adds a
// per-output-channel bias, applies the selected activation and buffers the
// result in a 2-entry valid/ready FIFO.
// Ports:
//   clk         in  1       clock, rising edge
//   rst         in  1       synchronous active-high reset
//   in_valid    in  1       partial-sum beat valid (no backpressure)
//   in_sum      in  DATA_W  signed partial sum
//   num_groups  in  GRP_W   groups per output (0 means 2**GRP_W)
//   bias        in  DATA_W  signed bias
//   act_mode    in  2       activation select
//   out_valid   out 1       output buffer non-empty
//   out_ready   in  1       consumer accepts out_data
//   out_data    out DATA_W  signed activated result at FIFO head
//   busy        out 1       group accumulation in progress
//   overrun     out 1       sticky: a result was dropped on a full buffer
// -----------------------------------------------------------------------------
module psum_accum_act
    import psum_act_pkg::*;
#(
    parameter int DATA_W = 14,
    parameter int FRAC_W = 8,
    parameter int GRP_W  = 6,
    parameter int ACC_W  = DATA_W + GRP_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_sum,
    input  logic [GRP_W-1:0]         num_groups,
    input  logic signed [DATA_W-1:0] bias,
    input  logic [1:0]               act_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     busy,
    output logic                     overrun
);

    localparam int Y_W = ACC_W + 1;

    logic [GRP_W-1:0]         r_grp_cnt;
    logic signed [ACC_W-1:0]  r_acc;
    logic [GRP_W-1:0]         r_groups;
    logic signed [DATA_W-1:0] r_bias;
    act_mode_e                r_mode;
    logic signed [Y_W-1:0]    r_y;
    logic                     r_s1_valid;
    act_mode_e                r_s1_mode;
    logic signed [DATA_W-1:0] r_mem [2];
    logic                     r_wr_ptr;
    logic                     r_rd_ptr;
    logic [1:0]               r_count;
    logic                     r_overrun;

    logic                     w_first;
    logic [GRP_W-1:0]         w_last_idx;
    logic                     w_last;
    logic signed [DATA_W-1:0] w_bias;
    act_mode_e                w_mode;
    logic signed [ACC_W-1:0]  w_sum_ext;
    logic signed [ACC_W-1:0]  w_acc_base;
    logic signed [ACC_W-1:0]  w_acc_next;
    logic signed [Y_W-1:0]    w_y_next;
    logic signed [DATA_W-1:0] w_act;
    logic                     w_pop;
    logic                     w_full;
    logic                     w_push;

    // On the first beat of a group the live config is used directly (it is
    // also captured into the shadow registers); later beats use the shadows.
    // The last index is num_groups-1 in GRP_W bits, so a count of 0 wraps to
    // all ones, i.e. 2**GRP_W groups.
    always_comb begin
        w_first    = (r_grp_cnt == '0);
        w_last_idx = (w_first ? num_groups : r_groups) - GRP_W'(1);
        w_last     = (r_grp_cnt == w_last_idx);
        w_bias     = w_first ? bias : r_bias;
        w_mode     = w_first ? act_mode_e'(act_mode) : r_mode;
        w_sum_ext  = ACC_W'(in_sum);
        w_acc_base = w_first ? '0 : r_acc;
        w_acc_next = w_acc_base + w_sum_ext;
        w_y_next   = Y_W'(w_acc_base) + Y_W'(w_sum_ext) + Y_W'(w_bias);
    end

    // Stage 0: group accumulation. The final beat hands the biased sum and
    // its activation mode to stage 1 and restarts the group counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grp_cnt  <= '0;
            r_acc      <= '0;
            r_groups   <= '0;
            r_bias     <= '0;
            r_mode     <= ACT_NONE;
            r_y        <= '0;
            r_s1_valid <= 1'b0;
            r_s1_mode  <= ACT_NONE;
        end else begin
            r_s1_valid <= 1'b0;
            if (in_valid) begin
                if (w_first) begin
                    r_groups <= num_groups;
                    r_bias   <= bias;
                    r_mode   <= act_mode_e'(act_mode);
                end
                r_acc <= w_acc_next;
                if (w_last) begin
                    r_grp_cnt  <= '0;
                    r_y        <= w_y_next;
                    r_s1_valid <= 1'b1;
                    r_s1_mode  <= w_mode;
                end else begin
                    r_grp_cnt <= r_grp_cnt + GRP_W'(1);
                end
            end
        end
    end

    act_unit #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .Y_W    (Y_W)
    ) u_act (
        .i_y    (r_y),
        .i_mode (r_s1_mode),
        .o_act  (w_act)
    );

    // A push into a full buffer is still accepted when the head is popped on
    // the same edge, because that frees the slot being written.
    always_comb begin
        w_pop  = out_valid && out_ready;
        w_full = (r_count == 2'd2);
        w_push = r_s1_valid && (!w_full || w_pop);
    end

    // 2-entry output FIFO with sticky overrun on a dropped result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem[0]  <= '0;
            r_mem[1]  <= '0;
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_count   <= 2'd0;
            r_overrun <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_act;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
            if (r_s1_valid && !w_push) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign out_valid = (r_count != 2'd0);
    assign out_data  = r_mem[r_rd_ptr];
    assign busy      = (r_grp_cnt != '0);
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_psum_accum_act.sv
// -----------------------------------------------------------------------------
// tb_psum_accum_act
// Self-checking bench for psum_accum_act: a table of group vectors streamed
// back to back, a scoreboard queue of expected results popped on every
// output handshake, and hand-written sequences for latency, buffer-full,
// overrun, mid-group reset and the 2**GRP_W group count.
// -----------------------------------------------------------------------------
module tb_psum_accum_act;

    localparam int DATA_W = 14;
    localparam int FRAC_W = 8;
    localparam int GRP_W  = 6;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     in_valid;
    logic signed [DATA_W-1:0] in_sum;
    logic [GRP_W-1:0]         num_groups;
    logic signed [DATA_W-1:0] bias;
    logic [1:0]               act_mode;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_data;
    logic                     busy;
    logic                     overrun;

    int total = 0;
    int bad   = 0;
    int expQ[$];

    typedef struct {
        int groups;
        int biasVal;
        int mode;
        int nBeats;
        int beats[4];
        int expected;
    } vec_t;

    vec_t vecs[16];
    int   nVec = 0;

    psum_accum_act #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .GRP_W  (GRP_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_sum     (in_sum),
        .num_groups (num_groups),
        .bias       (bias),
        .act_mode   (act_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drive one beat just after a rising edge; it is sampled on the next one.
    task automatic applyStimulus(input int sum, input int groups, input int biasVal, input int mode);
        in_valid   = 1'b1;
        in_sum     = 14'(sum);
        num_groups = 6'(groups);
        bias       = 14'(biasVal);
        act_mode   = 2'(mode);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        for (int c = 0; c < 100 && expQ.size() != 0; c++) begin
            @(posedge clk);
        end
        @(posedge clk);
        #2;
        checkOutput(name, expQ.size(), 0);
    endtask

    task automatic addVec(input int g, input int b, input int m, input int n,
                          input int b0, input int b1, input int b2, input int b3,
                          input int e);
        vecs[nVec].groups   = g;
        vecs[nVec].biasVal  = b;
        vecs[nVec].mode     = m;
        vecs[nVec].nBeats   = n;
        vecs[nVec].beats[0] = b0;
        vecs[nVec].beats[1] = b1;
        vecs[nVec].beats[2] = b2;
        vecs[nVec].beats[3] = b3;
        vecs[nVec].expected = e;
        nVec++;
    endtask

    // Scoreboard: every handshake observed away from the rising edge pops
    // the oldest expected result.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpectedOutput: got %0d, expected no output", out_data);
            end else begin
                checkOutput("scoreboard", int'(out_data), expQ.pop_front());
            end
        end
    end

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_sum     = '0;
        num_groups = '0;
        bias       = '0;
        act_mode   = '0;
        out_ready  = 1'b1;

        // Hard-swish values: y*clamp(y+768,0,1536)*43 >>> 16.
        // 1024 -> 1032 because 43/256 is slightly above 1/6; -100 floors to -44.
        addVec(3, -100, 0, 3,   378,   756, 1134, 0,  2168);
        addVec(1,    0, 3, 1,   256,     0,    0, 0,   172);
        addVec(1,    0, 3, 1, -1024,     0,    0, 0,     0);
        addVec(1,    0, 3, 1,  1024,     0,    0, 0,  1032);
        addVec(1,    0, 3, 1,  -100,     0,    0, 0,   -44);
        addVec(1,    0, 3, 1,  -256,     0,    0, 0,   -86);
        addVec(1,    0, 2, 1,  2000,     0,    0, 0,  1536);
        addVec(1,    0, 2, 1,   -50,     0,    0, 0,     0);
        addVec(1,    0, 1, 1,   -50,     0,    0, 0,     0);
        addVec(1,   20, 1, 1,   300,     0,    0, 0,   320);
        addVec(2,    0, 0, 2,  8000,  8000,    0, 0,  8191);
        addVec(2,    0, 0, 2, -8192, -8192,    0, 0, -8192);
        addVec(4,    7, 0, 4,    -1,    -2,   -3, -4,    -3);

        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        checkOutput("resetOutValid", out_valid, 0);
        checkOutput("resetOutData", int'(out_data), 0);
        checkOutput("resetBusy", busy, 0);
        checkOutput("resetOverrun", overrun, 0);

        // Table vectors, streamed back to back with out_ready held high.
        for (int i = 0; i < nVec; i++) begin
            expQ.push_back(vecs[i].expected);
            for (int j = 0; j < vecs[i].nBeats; j++) begin
                applyStimulus(vecs[i].beats[j], vecs[i].groups, vecs[i].biasVal, vecs[i].mode);
            end
        end
        waitDrain("tableDrain");

        // Latency and busy window for a 3-group output.
        expQ.push_back(2168);
        applyStimulus(378, 3, -100, 0);
        checkOutput("busyBeat1", busy, 1);
        applyStimulus(756, 3, -100, 0);
        checkOutput("busyBeat2", busy, 1);
        applyStimulus(1134, 3, -100, 0);
        checkOutput("busyAfterFinal", busy, 0);
        checkOutput("validTooEarly", out_valid, 0);
        @(posedge clk);
        #2;
        checkOutput("validLatency", out_valid, 1);
        checkOutput("latencyData", int'(out_data), 2168);
        waitDrain("latencyDrain");

        // Buffer full while the head is popped on the same edge as a push.
        out_ready = 1'b0;
        expQ.push_back(8);
        expQ.push_back(9);
        expQ.push_back(10);
        applyStimulus(8, 1, 0, 0);
        applyStimulus(9, 1, 0, 0);
        applyStimulus(10, 1, 0, 0);
        out_ready = 1'b1;
        waitDrain("popPushDrain");
        checkOutput("noOverrunOnPopPush", overrun, 0);

        // Overrun: third result dropped while the consumer stalls.
        out_ready = 1'b0;
        expQ.push_back(5);
        expQ.push_back(6);
        applyStimulus(5, 1, 0, 0);
        applyStimulus(6, 1, 0, 0);
        applyStimulus(7, 1, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        checkOutput("overrunSet", overrun, 1);
        checkOutput("stallValid", out_valid, 1);
        checkOutput("stallHead", int'(out_data), 5);
        repeat (2) @(posedge clk);
        #2;
        checkOutput("stallHeadStable", int'(out_data), 5);
        out_ready = 1'b1;
        waitDrain("overrunDrain");
        checkOutput("validFallsAfterDrain", out_valid, 0);

        // Reset mid-group discards the partial group; num_groups changes
        // after the first beat of a group are ignored.
        applyStimulus(10, 4, 0, 0);
        applyStimulus(10, 4, 0, 0);
        checkOutput("busyBeforeReset", busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        checkOutput("overrunAfterReset", overrun, 0);
        checkOutput("validAfterReset", out_valid, 0);
        checkOutput("busyAfterReset", busy, 0);
        checkOutput("dataAfterReset", int'(out_data), 0);
        expQ.push_back(40);
        applyStimulus(10, 4, 0, 0);
        applyStimulus(10, 2, 0, 0);
        applyStimulus(10, 2, 0, 0);
        checkOutput("busyIgnoresCfgChange", busy, 1);
        applyStimulus(10, 1, 0, 0);
        waitDrain("resetDrain");

        // num_groups = 0 selects the full 2**GRP_W group count.
        expQ.push_back(6400);
        for (int k = 0; k < 63; k++) begin
            applyStimulus(100, 0, 0, 0);
        end
        checkOutput("busyAt63of64", busy, 1);
        applyStimulus(100, 0, 0, 0);
        checkOutput("busyAfter64", busy, 0);
        waitDrain("maxGroupsDrain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
